// File: rtl/ifetch_bus_ctrl.sv
// ============================================================================
// ifetch_bus_ctrl
// ----------------------------------------------------------------------------
// Instruction-fetch bus controller. It sits between the PC register and a
// req/ack instruction memory bus. Each enabled PC value becomes one bus read.
// A stall request is raised toward CTRL while that read is outstanding. The
// fetched word is then shown to IF/ID and held for as long as IF/ID is
// stalled.
//
// A flush abandons the current fetch. If the read has not been acknowledged
// yet, it is drained, because the bus cannot abort a read in progress. A read
// that goes unacknowledged for TIMEOUT cycles produces a fetch error, and the
// word shown is a NOP (zero).
//
// Parameters
//   TIMEOUT      max cycles a read may wait for ack (1..65535)
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   stall_i      pipeline stall vector from CTRL (bit 1 = IF/ID stalled)
//   flush_i      exception flush from CTRL
//   cpu_ce_i     fetch enable
//   cpu_addr_i   current PC
//   cpu_data_o   instruction to IF/ID (zero unless a word is presented)
//   stallreq_o   stall request to CTRL
//   fetch_err_o  presented word is the NOP from a timed-out fetch
//   bus_req_o    read request
//   bus_addr_o   read address
//   bus_ack_i    read complete, bus_rdata_i valid
//   bus_rdata_i  read data
// ============================================================================
module ifetch_bus_ctrl #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall_i,
    input  logic        flush_i,
    input  logic        cpu_ce_i,
    input  logic [31:0] cpu_addr_i,
    output logic [31:0] cpu_data_o,
    output logic        stallreq_o,
    output logic        fetch_err_o,
    output logic        bus_req_o,
    output logic [31:0] bus_addr_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i
);

    localparam int unsigned    TW    = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]  TLAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, HOLD, DRAIN} state_t;

    state_t         state_q;
    logic [31:0]    inst_buf_q;
    logic           err_flag_q;
    logic           bus_req_q;
    logic [31:0]    bus_addr_q;
    logic [TW-1:0]  tcnt_q;

    logic           launch;
    logic           tmo;
    logic           unused_stall;

    // Only the IF/ID bit of the stall vector matters to the fetch stage.
    assign unused_stall = ^{stall_i[5:2], stall_i[0]};

    assign launch = (state_q == IDLE) && cpu_ce_i && !flush_i;
    assign tmo    = (tcnt_q == TLAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            inst_buf_q <= '0;
            err_flag_q <= 1'b0;
            bus_req_q  <= 1'b0;
            bus_addr_q <= '0;
            tcnt_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (launch) begin
                        bus_req_q  <= 1'b1;
                        bus_addr_q <= cpu_addr_i;
                        tcnt_q     <= '0;
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    if (flush_i && bus_ack_i) begin
                        // The read completed in the flush cycle, so its data is simply dropped.
                        bus_req_q <= 1'b0;
                        state_q   <= IDLE;
                    end else if (flush_i) begin
                        state_q   <= DRAIN;
                    end else if (bus_ack_i) begin
                        inst_buf_q <= bus_rdata_i;
                        err_flag_q <= 1'b0;
                        bus_req_q  <= 1'b0;
                        state_q    <= HOLD;
                    end else if (tmo) begin
                        inst_buf_q <= '0;
                        err_flag_q <= 1'b1;
                        bus_req_q  <= 1'b0;
                        state_q    <= HOLD;
                    end else begin
                        tcnt_q <= tcnt_q + TW'(1);
                    end
                end
                HOLD: begin
                    // The word leaves when IF/ID takes it or a flush kills it.
                    if (flush_i || !stall_i[1]) begin
                        err_flag_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                DRAIN: begin
                    // Wait out the abandoned read. Its data and any timeout are discarded silently.
                    if (bus_ack_i || tmo) begin
                        bus_req_q <= 1'b0;
                        state_q   <= IDLE;
                    end else begin
                        tcnt_q <= tcnt_q + TW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus_req_o   = bus_req_q;
    assign bus_addr_o  = bus_addr_q;
    assign cpu_data_o  = (state_q == HOLD) ? inst_buf_q : 32'h0;
    assign fetch_err_o = (state_q == HOLD) && err_flag_q;
    // Qualified with rst so that the request drops at the same moment as reset, before any clock edge.
    assign stallreq_o  = rst && (launch || (state_q == BUSY) || (state_q == DRAIN));

endmodule

// File: tb/tb_ifetch_bus_ctrl.sv
module tb_ifetch_bus_ctrl;

    localparam int TO = 6;

    logic        clk;
    logic        rst;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic        cpu_ce_i;
    logic [31:0] cpu_addr_i;
    logic [31:0] cpu_data_o;
    logic        stallreq_o;
    logic        fetch_err_o;
    logic        bus_req_o;
    logic [31:0] bus_addr_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;

    int n_chk  = 0;
    int n_pass = 0;

    ifetch_bus_ctrl #(.TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .stall_i    (stall_i),
        .flush_i    (flush_i),
        .cpu_ce_i   (cpu_ce_i),
        .cpu_addr_i (cpu_addr_i),
        .cpu_data_o (cpu_data_o),
        .stallreq_o (stallreq_o),
        .fetch_err_o(fetch_err_o),
        .bus_req_o  (bus_req_o),
        .bus_addr_o (bus_addr_o),
        .bus_ack_i  (bus_ack_i),
        .bus_rdata_i(bus_rdata_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Transaction-level view of the fetch stage:
    //   m_out   : a bus read is outstanding, issued at m_addr, waiting m_wait cycles
    //   m_dead  : that read was flushed and its result will be thrown away
    //   m_have  : a fetched word (m_word / m_err) is being presented to IF/ID
    bit          m_out, m_dead, m_have, m_err;
    int          m_wait;
    logic [31:0] m_addr, m_word;

    task automatic model_reset();
        m_out = 0; m_dead = 0; m_have = 0; m_err = 0;
        m_wait = 0; m_addr = '0; m_word = '0;
    endtask

    task automatic model_step();
        if (m_have) begin
            if (flush_i || !stall_i[1]) begin
                m_have = 0;
                m_err  = 0;
            end
        end else if (m_out) begin
            if (m_dead) begin
                if (bus_ack_i || m_wait == TO - 1) m_out = 0;
                else m_wait++;
            end else if (flush_i) begin
                if (bus_ack_i) m_out = 0;
                else m_dead = 1;
            end else if (bus_ack_i) begin
                m_out = 0; m_have = 1; m_word = bus_rdata_i; m_err = 0;
            end else if (m_wait == TO - 1) begin
                m_out = 0; m_have = 1; m_word = '0; m_err = 1;
            end else begin
                m_wait++;
            end
        end else if (cpu_ce_i && !flush_i) begin
            m_out = 1; m_dead = 0; m_wait = 0; m_addr = cpu_addr_i;
        end
    endtask

    // One clock cycle: compare at the falling edge, advance the model, step past the rising edge.
    task automatic cyc();
        @(negedge clk);
        chk("bus_req",  {31'b0, bus_req_o},   {31'b0, m_out});
        chk("bus_addr", bus_addr_o,           m_addr);
        chk("cpu_data", cpu_data_o,           m_have ? m_word : 32'h0);
        chk("fetch_err",{31'b0, fetch_err_o}, {31'b0, m_have && m_err});
        chk("stallreq", {31'b0, stallreq_o},
            {31'b0, m_out || (!m_have && cpu_ce_i && !flush_i)});
        model_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0; stall_i = '0; flush_i = 0; cpu_ce_i = 0;
        cpu_addr_i = '0; bus_ack_i = 0; bus_rdata_i = '0;
        model_reset();
        #12;
        chk("rst_cpu_data",  cpu_data_o, 32'h0);
        chk("rst_stallreq",  {31'b0, stallreq_o}, 32'h0);
        chk("rst_fetch_err", {31'b0, fetch_err_o}, 32'h0);
        chk("rst_bus_req",   {31'b0, bus_req_o}, 32'h0);
        chk("rst_bus_addr",  bus_addr_o, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Zero-wait fetch from PC 0x04
        cpu_ce_i = 1; cpu_addr_i = 32'h04;
        cyc();
        chk("s1_req", {31'b0, bus_req_o}, 32'h1);
        chk("s1_addr", bus_addr_o, 32'h04);
        bus_ack_i = 1; bus_rdata_i = 32'h3C010001;
        cyc();
        chk("s1_word", cpu_data_o, 32'h3C010001);
        chk("s1_nostall", {31'b0, stallreq_o}, 32'h0);
        bus_ack_i = 0; cpu_addr_i = 32'h08;
        cyc();
        chk("s1_idle_data", cpu_data_o, 32'h0);
        cyc();
        chk("s1_next_addr", bus_addr_o, 32'h08);

        // Ack delayed: request and address stable while waiting
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("s2_req_stable", {31'b0, bus_req_o}, 32'h1);
            chk("s2_addr_stable", bus_addr_o, 32'h08);
        end
        bus_ack_i = 1; bus_rdata_i = 32'h2408000A;
        cyc();
        chk("s2_word", cpu_data_o, 32'h2408000A);

        // IF/ID stalled for 3 cycles: word held, no new request
        bus_ack_i = 0; stall_i = 6'b000010;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("s3_hold", cpu_data_o, 32'h2408000A);
            chk("s3_noreq", {31'b0, bus_req_o}, 32'h0);
        end
        stall_i = '0;
        cyc();

        // Flush while BUSY, ack 2 cycles later with data that must never show
        cpu_addr_i = 32'h10;
        cyc();
        flush_i = 1;
        cyc();
        flush_i = 0; cpu_addr_i = 32'h20;
        cyc();
        chk("s4_drain_data", cpu_data_o, 32'h0);
        bus_ack_i = 1; bus_rdata_i = 32'hDEADBEEF;
        cyc();
        chk("s4_dropped", cpu_data_o, 32'h0);
        bus_ack_i = 0;
        cyc();
        chk("s4_new_addr", bus_addr_o, 32'h20);

        // No ack: timeout after TO BUSY cycles
        for (int i = 0; i < TO - 1; i++) cyc();
        chk("s5_still_req", {31'b0, bus_req_o}, 32'h1);
        cyc();
        chk("s5_req_drop", {31'b0, bus_req_o}, 32'h0);
        chk("s5_err", {31'b0, fetch_err_o}, 32'h1);
        chk("s5_nop", cpu_data_o, 32'h0);
        cyc();

        // Reset asserted mid-transaction
        cpu_addr_i = 32'h40;
        cyc();
        #2 rst = 1'b0;
        #1;
        chk("s6_req_async", {31'b0, bus_req_o}, 32'h0);
        chk("s6_stall_async", {31'b0, stallreq_o}, 32'h0);
        chk("s6_addr_async", bus_addr_o, 32'h0);
        model_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        cyc();
        chk("s6_restart", bus_addr_o, 32'h40);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            cpu_ce_i    = ($urandom_range(0, 9) < 8);
            flush_i     = ($urandom_range(0, 9) == 0);
            stall_i     = 6'($urandom) & 6'b111101;
            stall_i[1]  = ($urandom_range(0, 9) < 4);
            bus_ack_i   = ($urandom_range(0, 99) < 30);
            cpu_addr_i  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            bus_rdata_i = $urandom;
            cyc();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
